// File: rtl/shift_req_queue.sv
// Request FIFO and registered result slot in front of the 32-bit barrel shifter.
// Optional `SHIFT_REQ_QUEUE_STATS_EN adds saturating res_count/stall_count outputs.
module shift_req_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic [7:0]    in_cmd,
  output logic [31:0]   sh_data,
  output logic [7:0]    sh_cmd,
  input  logic [31:0]   sh_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic [7:0]    res_cmd,
  output logic [CW-1:0] occupancy
`ifdef SHIFT_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]   res_count,
  output logic [15:0]   stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   data_mem [DEPTH];
  logic [7:0]    cmd_mem  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          nonempty;
  logic          slot_free;
  logic          push;
  logic          pop;

  assign occupancy = count;
  assign nonempty  = (count != '0);
  // No write-through: a full queue refuses even when the head is leaving.
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign slot_free = ~res_valid | res_ready;
  assign pop       = nonempty & slot_free;

  assign sh_data = nonempty ? data_mem[rd_ptr] : '0;
  assign sh_cmd  = nonempty ? cmd_mem[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr] <= in_data;
      cmd_mem[wr_ptr]  <= in_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // flush clears only the valid flag; the last result stays readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cmd   <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_data  <= sh_out;
      res_cmd   <= sh_cmd;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef SHIFT_REQ_QUEUE_STATS_EN
  logic handshake;
  logic stalled;

  assign handshake = res_valid & res_ready;
  assign stalled   = in_valid & ~in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count   <= '0;
      stall_count <= '0;
    end else if (flush) begin
      res_count   <= '0;
      stall_count <= '0;
    end else begin
      if (handshake && res_count != 16'hFFFF)  res_count   <= res_count + 16'd1;
      if (stalled && stall_count != 16'hFFFF)  stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_req_queue.sv
// Directed bench for shift_req_queue; the barrel shifter is modelled by refShift.
// Stats checks are compiled in when SHIFT_REQ_QUEUE_STATS_EN is defined.
module tb_shift_req_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_cmd;
  logic [31:0] sh_data;
  logic [7:0]  sh_cmd;
  logic [31:0] sh_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [7:0]  res_cmd;
  logic [2:0]  occupancy;
`ifdef SHIFT_REQ_QUEUE_STATS_EN
  logic [15:0] res_count;
  logic [15:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  shift_req_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cmd(in_cmd),
    .sh_data(sh_data), .sh_cmd(sh_cmd), .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cmd(res_cmd),
    .occupancy(occupancy)
`ifdef SHIFT_REQ_QUEUE_STATS_EN
    , .res_count(res_count), .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cmd[6:5]: 0 sll, 1 srl, 2 sra, 3 rotl; cmd[4:0] is the shift amount.
  function automatic logic [31:0] refShift(input logic [31:0] d, input logic [7:0] c);
    logic [63:0] dd;
    logic [4:0]  amt;
    amt = c[4:0];
    dd  = {d, d} << amt;
    case (c[6:5])
      2'd0:    return d << amt;
      2'd1:    return d >> amt;
      2'd2:    return 32'($signed(d) >>> amt);
      default: return dd[63:32];
    endcase
  endfunction

  assign sh_out = refShift(sh_data, sh_cmd);

  task automatic checkOutput(input string tag, input logic [39:0] actual, input logic [39:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [7:0] c,
                               input logic rr, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_cmd    = c;
    res_ready = rr;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves 3 entries queued and the first request parked in the result slot.
  task automatic queueThree(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, base + 32'(i), 8'(8'h10 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] fd [6];
  logic [7:0]  fc [6];
  logic [2:0]  bp_occ [10];
  logic [39:0] sb [$];
  logic [39:0] exp_res;
  logic [31:0] d;
  logic [7:0]  c;
  int          got;
  int          sent;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    #12;
    checkOutput("rst_occ",      40'(occupancy), 40'(0));
    checkOutput("rst_in_ready", 40'(in_ready),  40'(1));
    checkOutput("rst_res_valid",40'(res_valid), 40'(0));
    checkOutput("rst_res",      {res_data, res_cmd}, 40'(0));
    checkOutput("rst_sh",       {sh_data, sh_cmd},   40'(0));
`ifdef SHIFT_REQ_QUEUE_STATS_EN
    checkOutput("rst_stats",    40'({res_count, stall_count}), 40'(0));
`endif
    rst_n = 1'b1;
    tick();

    // Single request: sll by 1 of 0xF0 gives 0x1E0
    applyStimulus(1'b1, 32'h0000_00F0, 8'h01, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    checkOutput("single_occ1",   40'(occupancy), 40'(1));
    checkOutput("single_rv_k",   40'(res_valid), 40'(0));
    checkOutput("single_head",   {sh_data, sh_cmd}, {32'h0000_00F0, 8'h01});
    tick();
    checkOutput("single_rv_k1",  40'(res_valid), 40'(1));
    checkOutput("single_res",    {res_data, res_cmd}, {32'h0000_01E0, 8'h01});
    tick();
    checkOutput("single_rv_drop",40'(res_valid), 40'(0));
    checkOutput("single_hold",   {res_data, res_cmd}, {32'h0000_01E0, 8'h01});

    // Fill/full
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    tick();
    fd[0] = 32'h1111_0001; fc[0] = 8'h04;
    fd[1] = 32'h8000_00F0; fc[1] = 8'h22;
    fd[2] = 32'h8765_4321; fc[2] = 8'h48;
    fd[3] = 32'hF000_000F; fc[3] = 8'h63;
    fd[4] = 32'hDEAD_BEEF; fc[4] = 8'h00;
    fd[5] = 32'h0000_FFFF; fc[5] = 8'h2F;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, fd[i], fc[i], 1'b0, 1'b0);
      checkOutput("fill_ready", 40'(in_ready), 40'(1));
      tick();
    end
    checkOutput("full_occ",   40'(occupancy), 40'(4));
    checkOutput("full_ready", 40'(in_ready),  40'(0));
    checkOutput("full_slot",  {res_data, res_cmd}, {refShift(fd[0], fc[0]), fc[0]});
    applyStimulus(1'b1, fd[5], fc[5], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_occ", 40'(occupancy), 40'(4));
    end
    applyStimulus(1'b1, fd[5], fc[5], 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) begin
      tick();
      if (i == 2) applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      checkOutput("drain_valid", 40'(res_valid), 40'(1));
      checkOutput("drain_res", {res_data, res_cmd}, {refShift(fd[i], fc[i]), fc[i]});
`ifdef SHIFT_REQ_QUEUE_STATS_EN
      if (i == 5) checkOutput("stats_res5", 40'(res_count), 40'(5));
`endif
    end
    tick();
    checkOutput("drain_empty", {7'(occupancy), 33'(res_valid)}, 40'(0));
`ifdef SHIFT_REQ_QUEUE_STATS_EN
    checkOutput("stats_stall", 40'(stall_count), 40'(4));
    checkOutput("stats_res6",  40'(res_count),   40'(6));
`endif

    // Backpressure: after edge n the occupancy is 1,1,2,3,4,4,...
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    tick();
    bp_occ = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'hA5A5_0000 + 32'(i), 8'h21, 1'b0, 1'b0);
      tick();
      if (i >= 2) begin
        checkOutput("bp_res", {res_data, res_cmd}, {refShift(32'hA5A5_0000, 8'h21), 8'h21});
        checkOutput("bp_valid", 40'(res_valid), 40'(1));
      end
      if (i < 10) checkOutput("bp_occ", 40'(occupancy), 40'(bp_occ[i]));
    end

    // Streaming
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    tick();
    got = 0;
    sent = 0;
    for (int cyc = 0; cyc < 100 && got < 64; cyc++) begin
      if (sent < 64) begin
        d = $urandom;
        c = 8'($urandom_range(0, 255));
        applyStimulus(1'b1, d, c, 1'b1, 1'b0);
        checkOutput("stream_ready", 40'(in_ready), 40'(1));
        sb.push_back({refShift(d, c), c});
        sent++;
      end else begin
        applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      end
      tick();
      checkOutput("stream_occ_le1", 40'(occupancy <= 3'd1), 40'(1));
      if (got > 0) checkOutput("stream_bubble", 40'(res_valid), 40'(1));
      if (res_valid) begin
        exp_res = (sb.size() > 0) ? sb.pop_front() : 40'hFF_FFFF_FFFF;
        checkOutput("stream_res", {res_data, res_cmd}, exp_res);
        got++;
      end
    end
    checkOutput("stream_total", 40'(got), 40'(64));
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    tick();

    // Flush with a request offered in the same cycle
    queueThree(32'h0BAD_0000);
    checkOutput("preflush_occ", 40'(occupancy), 40'(3));
    applyStimulus(1'b1, 32'hCAFE_F00D, 8'h7E, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    checkOutput("flush_occ", 40'(occupancy), 40'(0));
    checkOutput("flush_rv",  40'(res_valid), 40'(0));
    checkOutput("flush_sh",  {sh_data, sh_cmd}, 40'(0));
    checkOutput("flush_res_kept", {res_data, res_cmd}, {refShift(32'h0BAD_0000, 8'h10), 8'h10});
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("flush_dropped", {7'(occupancy), 33'(res_valid)}, 40'(0));
    end

    // Asynchronous reset between edges
    queueThree(32'h5EED_0000);
    checkOutput("prerst_rv", 40'(res_valid), 40'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_occ",   40'(occupancy), 40'(0));
    checkOutput("arst_rv",    40'(res_valid), 40'(0));
    checkOutput("arst_res",   {res_data, res_cmd}, 40'(0));
    checkOutput("arst_sh",    {sh_data, sh_cmd},   40'(0));
    checkOutput("arst_ready", 40'(in_ready), 40'(1));
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_occ", 40'(occupancy), 40'(0));

`ifdef SHIFT_REQ_QUEUE_STATS_EN
    // Saturation: 65540 handshakes
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(1'b1, 32'(i), 8'h05, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("stats_sat", 40'(res_count), 40'(16'hFFFF));
    checkOutput("stats_nostall", 40'(stall_count), 40'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
